hyperram_req_sequencer: RTL and testbench
=========================================

// Module: hyperram_req_sequencer
// PURPOSE
// - Front end that sits directly upstream of the HyperRAM PHY/controller and drives its
//   iEn/iOpReq/oOpDone handshake.
// - Runs the power-up sequence: hardware reset, then an optional ID check.
// - Then accepts single host read/write commands, issues each to the controller and
//   returns one response per command.
// - Guards every operation with a timeout.
// PARAMETERS
// - TIMEOUT_CYC  1023           cycles allowed from op issue to iCtrlOpDone; must be >=16
// - EXPECTED_ID  32'h0C81_0C81  value compared against the ID read (used only with the ID check)
// - ADDR_W       32             host address width
// PORTS
// - iClk          in   1       system clock; the same clock that drives the controller
// - iRst          in   1       synchronous, active-high reset
// - iCmdValid     in   1       host command valid
// - oCmdReady     out  1       command accepted when iCmdValid&&oCmdReady
// - iCmdWrite     in   1       1 = write, 0 = read
// - iCmdAddr      in   ADDR_W  word address
// - iCmdWrData    in   32      write data
// - oRspValid     out  1       one-cycle response pulse
// - oRspErr       out  1       qualifies oRspValid; 1 = command timed out
// - oRspData      out  32      read data; 0 for writes
// - oInitDone     out  1       high once the init sequence has passed
// - oErrTimeout   out  1       sticky; any operation timed out
// - oErrId        out  1       sticky; ID mismatch
// - oCtrlEn       out  1       to controller iEn
// - oCtrlOpReq    out  2       to controller iOpReq (00 rst, 01 reg rd, 10 mem wr, 11 mem rd)
// - iCtrlOpDone   in   1       from controller; one-cycle pulse
// - oCtrlAddr     out  ADDR_W  latched command address
// - oCtrlWrData   out  32      latched write data
// - iCtrlRdData   in   32      controller read/ID data; valid in the iCtrlOpDone cycle
// BEHAVIOUR
// - Reset values: all outputs 0, oCtrlOpReq=2'b00, state=S_INIT_RST, timer=0. An iRst
//   asserted mid-operation aborts immediately, drops oCtrlEn, and the next cycle restarts init.
// - All outputs are registered. States and transitions:
//   - S_INIT_RST: oCtrlEn=1, OpReq=00. On iCtrlOpDone go to S_HOLD, then S_INIT_ID
//     (ID check built in) or S_IDLE with oInitDone=1 (ID check not built in).
//   - S_INIT_ID: OpReq=01. On done compare iCtrlRdData with EXPECTED_ID.
//     - Equal: go to S_HOLD, then S_IDLE, and set oInitDone=1.
//     - Not equal: set oErrId=1 and go to S_ERR.
//   - S_IDLE: oCmdReady=1 and oCtrlEn=0.
//     - On accept: latch addr/data/dir, set oCmdReady=0, next cycle oCtrlEn=1.
//     - OpReq=10 (write) goes to S_WR; OpReq=11 (read) goes to S_RD.
//   - S_WR / S_RD: hold oCtrlEn=1 with OpReq stable until iCtrlOpDone. In the done cycle,
//     capture iCtrlRdData (read) or 0 (write), then go to S_HOLD.
//   - S_HOLD: keep oCtrlEn=1 for exactly one cycle so the controller returns to step 0, then
//     drop oCtrlEn. For a host command, pulse oRspValid (oRspErr=0) on that S_HOLD exit edge.
//   - S_ERR: terminal until iRst. oCmdReady=0, oCtrlEn=0, oInitDone=0.
// - Latency and throughput:
//   - Accept-to-oCtrlEn: 1 cycle.
//   - Done-to-oRspValid: 2 cycles.
//   - At least one oCtrlEn=0 cycle separates consecutive operations.
// - Timeout: the timer clears on every op issue and increments while waiting for done.
//   - At count TIMEOUT_CYC-1: oCtrlEn=0, oErrTimeout=1.
//   - Host command: oRspValid=1, oRspErr=1, oRspData=0, then S_IDLE.
//   - Init op: go to S_ERR.
// - Other boundary rules:
//   - Done and timeout in the same cycle: done wins.
//   - iCtrlOpDone outside S_INIT_*/S_WR/S_RD is ignored.
//   - iCmdValid while oCmdReady=0 is not accepted; host inputs must be held by the host.
//   - oCtrlAddr/oCtrlWrData stay constant from accept until the next accept.
// CONFIGURATION
// - HYPERRAM_ID_CHECK_EN defined: S_INIT_ID is built in, EXPECTED_ID is used, and oErrId
//   can assert.
// - HYPERRAM_ID_CHECK_EN undefined: the S_INIT_ID logic is absent, init is the reset op
//   only, and oErrId is tied to 0.
// TESTING
// - Init with the model returning 32'h0C81_0C81 (ID check EN): OpReq 00 then 01 are issued,
//   oInitDone=1 and oCmdReady=1.
// - ID model returns 32'hDEAD_BEEF: oErrId=1, S_ERR, oCmdReady stays 0 through 100 cycles.
// - Write addr=32'h0000_0100, data=32'hA5A5_5A5A: OpReq=10 with the latched values, oRspValid
//   pulses with oRspErr=0 and oRspData=0.
// - Read addr=32'h0000_0104, model data=32'h1234_5678: oRspData=32'h1234_5678 exactly
//   2 cycles after done.
// - Model never asserts done on a read: after TIMEOUT_CYC cycles oRspErr=1 and
//   oErrTimeout=1; a following write completes normally.
// - iRst pulsed while in S_RD: oCtrlEn=0 on the next cycle and init restarts with OpReq=00.

Source files
------------

// File: rtl/hyperram_req_sequencer.sv
// Sequencer in front of the HyperRAM controller: runs the power-up reset (plus an optional ID
// check), then turns single host read/write commands into timed controller operations.
// Optional ID check is built when HYPERRAM_ID_CHECK_EN is defined.
module hyperram_req_sequencer #(
  parameter int          TIMEOUT_CYC = 1023,
  parameter logic [31:0] EXPECTED_ID = 32'h0C81_0C81,
  parameter int          ADDR_W      = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic              iCmdWrite,
  input  logic [ADDR_W-1:0] iCmdAddr,
  input  logic [31:0]       iCmdWrData,
  output logic              oRspValid,
  output logic              oRspErr,
  output logic [31:0]       oRspData,
  output logic              oInitDone,
  output logic              oErrTimeout,
  output logic              oErrId,
  output logic              oCtrlEn,
  output logic [1:0]        oCtrlOpReq,
  input  logic              iCtrlOpDone,
  output logic [ADDR_W-1:0] oCtrlAddr,
  output logic [31:0]       oCtrlWrData,
  input  logic [31:0]       iCtrlRdData
);

  localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT_RST, S_INIT_ID, S_IDLE, S_WR, S_RD, S_HOLD, S_ERR
  } state_t;

  // Remembers which operation S_HOLD is finishing so it knows where to go next.
  typedef enum logic [1:0] {H_RST, H_ID, H_CMD} hold_t;

  state_t        state;
  hold_t         hold_kind;
  logic [TW-1:0] timer;
  logic          timed_out;

  assign timed_out = (timer == TIMER_LAST);

`ifndef HYPERRAM_ID_CHECK_EN
  logic [31:0] id_check_unused;
  assign id_check_unused = EXPECTED_ID;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= S_INIT_RST;
      hold_kind   <= H_RST;
      timer       <= '0;
      oCmdReady   <= 1'b0;
      oRspValid   <= 1'b0;
      oRspErr     <= 1'b0;
      oRspData    <= 32'h0;
      oInitDone   <= 1'b0;
      oErrTimeout <= 1'b0;
      oErrId      <= 1'b0;
      oCtrlEn     <= 1'b0;
      oCtrlOpReq  <= 2'b00;
      oCtrlAddr   <= '0;
      oCtrlWrData <= 32'h0;
    end else begin
      oRspValid <= 1'b0;
      oRspErr   <= 1'b0;
      case (state)
        // Init ops enter with oCtrlEn low; the first cycle here issues the op.
        S_INIT_RST: begin
          if (!oCtrlEn) begin
            oCtrlEn    <= 1'b1;
            oCtrlOpReq <= 2'b00;
            timer      <= '0;
          end else if (iCtrlOpDone) begin
            state     <= S_HOLD;
            hold_kind <= H_RST;
          end else if (timed_out) begin
            oCtrlEn     <= 1'b0;
            oErrTimeout <= 1'b1;
            state       <= S_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef HYPERRAM_ID_CHECK_EN
        S_INIT_ID: begin
          if (!oCtrlEn) begin
            oCtrlEn    <= 1'b1;
            oCtrlOpReq <= 2'b01;
            timer      <= '0;
          end else if (iCtrlOpDone) begin
            if (iCtrlRdData == EXPECTED_ID) begin
              state     <= S_HOLD;
              hold_kind <= H_ID;
            end else begin
              oErrId  <= 1'b1;
              oCtrlEn <= 1'b0;
              state   <= S_ERR;
            end
          end else if (timed_out) begin
            oCtrlEn     <= 1'b0;
            oErrTimeout <= 1'b1;
            state       <= S_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_IDLE: begin
          if (iCmdValid && oCmdReady) begin
            oCtrlAddr   <= iCmdAddr;
            oCtrlWrData <= iCmdWrData;
            oCmdReady   <= 1'b0;
            oCtrlEn     <= 1'b1;
            oCtrlOpReq  <= iCmdWrite ? 2'b10 : 2'b11;
            state       <= iCmdWrite ? S_WR : S_RD;
            timer       <= '0;
          end else begin
            oCmdReady <= 1'b1;
          end
        end
        // Done is tested before the timeout so a late done still completes the command.
        S_WR, S_RD: begin
          if (iCtrlOpDone) begin
            oRspData  <= (state == S_RD) ? iCtrlRdData : 32'h0;
            state     <= S_HOLD;
            hold_kind <= H_CMD;
          end else if (timed_out) begin
            oCtrlEn     <= 1'b0;
            oErrTimeout <= 1'b1;
            oRspValid   <= 1'b1;
            oRspErr     <= 1'b1;
            oRspData    <= 32'h0;
            oCmdReady   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_HOLD: begin
          oCtrlEn <= 1'b0;
          case (hold_kind)
            H_RST: begin
`ifdef HYPERRAM_ID_CHECK_EN
              state <= S_INIT_ID;
`else
              state     <= S_IDLE;
              oInitDone <= 1'b1;
              oCmdReady <= 1'b1;
`endif
            end
            H_ID: begin
              state     <= S_IDLE;
              oInitDone <= 1'b1;
              oCmdReady <= 1'b1;
            end
            H_CMD: begin
              state     <= S_IDLE;
              oCmdReady <= 1'b1;
              oRspValid <= 1'b1;
            end
            default: state <= S_ERR;
          endcase
        end
        S_ERR: begin
          oCmdReady <= 1'b0;
          oCtrlEn   <= 1'b0;
          oInitDone <= 1'b0;
        end
        default: begin
          oCtrlEn <= 1'b0;
          state   <= S_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_req_sequencer.sv
// Scoreboard bench for hyperram_req_sequencer: a small controller model answers operations,
// expected responses are queued at issue and checked by a separate response monitor.
module tb_hyperram_req_sequencer;

  localparam int TO = 20;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iCmdValid = 1'b0;
  logic        iCmdWrite = 1'b0;
  logic [31:0] iCmdAddr = 32'h0;
  logic [31:0] iCmdWrData = 32'h0;
  logic        iCtrlOpDone = 1'b0;
  logic [31:0] iCtrlRdData = 32'h0;
  logic        oCmdReady, oRspValid, oRspErr, oInitDone, oErrTimeout, oErrId, oCtrlEn;
  logic [31:0] oRspData, oCtrlAddr, oCtrlWrData;
  logic [1:0]  oCtrlOpReq;

  hyperram_req_sequencer #(.TIMEOUT_CYC(TO), .EXPECTED_ID(32'h0C81_0C81), .ADDR_W(32)) dut (
    .iClk(iClk), .iRst(iRst), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdWrite(iCmdWrite), .iCmdAddr(iCmdAddr), .iCmdWrData(iCmdWrData),
    .oRspValid(oRspValid), .oRspErr(oRspErr), .oRspData(oRspData),
    .oInitDone(oInitDone), .oErrTimeout(oErrTimeout), .oErrId(oErrId),
    .oCtrlEn(oCtrlEn), .oCtrlOpReq(oCtrlOpReq), .iCtrlOpDone(iCtrlOpDone),
    .oCtrlAddr(oCtrlAddr), .oCtrlWrData(oCtrlWrData), .iCtrlRdData(iCtrlRdData)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model: answers 3 cycles after oCtrlEn rises unless told to hang.
  logic        model_hang = 1'b0;
  logic [31:0] model_id = 32'h0C81_0C81;
  logic [31:0] model_rd = 32'h0;
  int          dly_cnt = 0;
  bit          given = 1'b0;
  int          done_cyc = 0;
  int          run = 0;
  int          last_run = 0;
  logic [1:0]  op_log[$];

  always @(negedge iClk) begin
    iCtrlOpDone = 1'b0;
    if (oCtrlEn) begin
      run++;
      if (!given && !model_hang) begin
        dly_cnt++;
        if (dly_cnt == 3) begin
          iCtrlOpDone = 1'b1;
          iCtrlRdData = (oCtrlOpReq == 2'b01) ? model_id :
                        (oCtrlOpReq == 2'b11) ? model_rd : 32'h0;
          given    = 1'b1;
          done_cyc = cyc;
          op_log.push_back(oCtrlOpReq);
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run     = 0;
      given   = 1'b0;
      dly_cnt = 0;
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  // Response monitor
  always @(negedge iClk) begin
    if (!iRst && oRspValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got err=%b data=%h, expected no response", oRspErr, oRspData);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_err", 32'(oRspErr), 32'(mon_e.err));
        check("rsp_data", oRspData, mon_e.data);
        if (!mon_e.err) check("rsp_latency", 32'(cyc - done_cyc), 32'd2);
      end
    end
  end

  task automatic wait_init();
    for (int k = 0; k < 300 && !oInitDone; k++) @(negedge iClk);
    check("init_done", 32'(oInitDone), 32'd1);
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    for (int k = 0; k < 500 && !oCmdReady; k++) @(negedge iClk);
    check("cmd_ready", 32'(oCmdReady), 32'd1);
    iCmdValid  = 1'b1;
    iCmdWrite  = wr;
    iCmdAddr   = addr;
    iCmdWrData = data;
    @(negedge iClk);
    iCmdValid = 1'b0;
    check("en_after_accept", 32'(oCtrlEn), 32'd1);
    check("ready_dropped", 32'(oCmdReady), 32'd0);
    check("opreq", 32'(oCtrlOpReq), wr ? 32'd2 : 32'd3);
    check("ctrl_addr", oCtrlAddr, addr);
    if (wr) check("ctrl_wrdata", oCtrlWrData, data);
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge iClk);
    check("rsp_drained", 32'(exp_q.size()), 32'd0);
    @(negedge iClk);
  endtask

  int bad_ready;

  initial begin
    repeat (3) @(negedge iClk);
    check("rst_en", 32'(oCtrlEn), 32'd0);
    check("rst_ready", 32'(oCmdReady), 32'd0);
    check("rst_initdone", 32'(oInitDone), 32'd0);
    check("rst_rspvalid", 32'(oRspValid), 32'd0);
    check("rst_opreq", 32'(oCtrlOpReq), 32'd0);
    check("rst_errto", 32'(oErrTimeout), 32'd0);
    check("rst_errid", 32'(oErrId), 32'd0);

    iRst = 1'b0;
    wait_init();
    check("ready_after_init", 32'(oCmdReady), 32'd1);
    check("init_op0", (op_log.size() > 0) ? 32'(op_log[0]) : 32'hFFFF_FFFF, 32'd0);
`ifdef HYPERRAM_ID_CHECK_EN
    check("init_op_count", 32'(op_log.size()), 32'd2);
    check("init_op1", (op_log.size() > 1) ? 32'(op_log[1]) : 32'hFFFF_FFFF, 32'd1);
`else
    check("init_op_count", 32'(op_log.size()), 32'd1);
`endif
    op_log.delete();

    exp_q.push_back('{err: 1'b0, data: 32'h0});
    send(1'b1, 32'h0000_0100, 32'hA5A5_5A5A);
    drain();

    model_rd = 32'h1234_5678;
    exp_q.push_back('{err: 1'b0, data: 32'h1234_5678});
    send(1'b0, 32'h0000_0104, 32'h0);
    drain();

    model_hang = 1'b1;
    exp_q.push_back('{err: 1'b1, data: 32'h0});
    send(1'b0, 32'h0000_0108, 32'h0);
    drain();
    check("timeout_sticky", 32'(oErrTimeout), 32'd1);
    check("timeout_en_cycles", 32'(last_run), 32'(TO));
    model_hang = 1'b0;
    exp_q.push_back('{err: 1'b0, data: 32'h0});
    send(1'b1, 32'h0000_010C, 32'hDEAD_CAFE);
    drain();
    check("timeout_still_sticky", 32'(oErrTimeout), 32'd1);

    model_hang = 1'b1;
    send(1'b0, 32'h0000_0110, 32'h0);
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    check("abort_en_low", 32'(oCtrlEn), 32'd0);
    model_hang = 1'b0;
    op_log.delete();
    iRst = 1'b0;
    @(negedge iClk);
    check("restart_en", 32'(oCtrlEn), 32'd1);
    check("restart_opreq", 32'(oCtrlOpReq), 32'd0);
    check("restart_errto_clr", 32'(oErrTimeout), 32'd0);
    wait_init();
    check("restart_op0", (op_log.size() > 0) ? 32'(op_log[0]) : 32'hFFFF_FFFF, 32'd0);

`ifdef HYPERRAM_ID_CHECK_EN
    model_id = 32'hDEAD_BEEF;
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    for (int k = 0; k < 300 && !oErrId; k++) @(negedge iClk);
    check("id_err", 32'(oErrId), 32'd1);
    bad_ready = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge iClk);
      if (oCmdReady || oCtrlEn || oInitDone) bad_ready++;
    end
    check("err_state_quiet", 32'(bad_ready), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
